// File: rtl/voq_in_arbiter_pkg.sv
// Shared build-time defaults and FSM state encoding for the VOQ ingress arbiter.
package voq_in_arbiter_pkg;

    localparam int PORT_NUB_TOTAL      = 4;
    localparam int DATA_WIDTH_DEF      = 8;
    localparam int OUTSTANDING_MAX_DEF = 2;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_XFER = 1'b1
    } arb_state_e;

endpackage

// File: rtl/voq_in_arbiter_rr_picker.sv
// Combinational round-robin search: first set bit of eligible at or after rr_ptr, wrapping.
module rr_picker #(
    parameter int PORT_NUB  = 4,
    parameter int WIDTH_SEL = 2
) (
    input  logic [PORT_NUB-1:0]  eligible,
    input  logic [WIDTH_SEL-1:0] rr_ptr,
    output logic [PORT_NUB-1:0]  grant_onehot,
    output logic [WIDTH_SEL-1:0] grant_idx,
    output logic                 grant_any
);

    localparam logic [WIDTH_SEL:0] NUB_EXT = (WIDTH_SEL+1)'(PORT_NUB);

    // One extra bit so ptr+offset never overflows before the wrap subtract.
    logic [WIDTH_SEL:0] pos;

    always_comb begin
        grant_onehot = '0;
        grant_idx    = '0;
        grant_any    = 1'b0;
        pos          = '0;
        for (int k = 0; k < PORT_NUB; k++) begin
            pos = {1'b0, rr_ptr} + (WIDTH_SEL+1)'(k);
            if (pos >= NUB_EXT) begin
                pos = pos - NUB_EXT;
            end
            if (!grant_any && eligible[pos[WIDTH_SEL-1:0]]) begin
                grant_onehot[pos[WIDTH_SEL-1:0]] = 1'b1;
                grant_idx                        = pos[WIDTH_SEL-1:0];
                grant_any                        = 1'b1;
            end
        end
    end

endmodule

// File: rtl/voq_in_arbiter.sv
// Round-robin frame arbiter feeding the VOQ ingress chain, with per-destination
// outstanding-frame credits released by the chain's done pulses.
module voq_in_arbiter
    import voq_in_arbiter_pkg::*;
#(
    parameter int PORT_NUB        = PORT_NUB_TOTAL,
    parameter int DATA_WIDTH      = DATA_WIDTH_DEF,
    parameter int OUTSTANDING_MAX = OUTSTANDING_MAX_DEF,
    parameter int WIDTH_SEL       = $clog2(PORT_NUB),
    parameter int WIDTH_PORT      = WIDTH_SEL + DATA_WIDTH
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [PORT_NUB-1:0]            req_valid,
    input  logic [PORT_NUB-1:0]            req_last,
    input  logic [PORT_NUB*DATA_WIDTH-1:0] req_data,
    input  logic [PORT_NUB*WIDTH_SEL-1:0]  req_nub,
    output logic [PORT_NUB-1:0]            req_ready,
    input  logic                           voq_full_in,
    input  logic [PORT_NUB-1:0]            done_in,
    output logic                           valid_out,
    output logic [WIDTH_PORT-1:0]          data_out,
    output logic [WIDTH_SEL-1:0]           nub_out,
    output logic                           err_out
);

    localparam int                   CW         = $clog2(OUTSTANDING_MAX + 1);
    localparam logic [CW-1:0]        CREDIT_MAX = CW'(OUTSTANDING_MAX);
    localparam logic [WIDTH_SEL-1:0] LAST_IDX   = WIDTH_SEL'(PORT_NUB - 1);

    arb_state_e                   state_q, state_d;
    logic [WIDTH_SEL-1:0]         rr_ptr_q, rr_ptr_d;
    logic [WIDTH_SEL-1:0]         gnt_q, gnt_d;
    logic [WIDTH_SEL-1:0]         dest_q, dest_d;
    logic [PORT_NUB-1:0][CW-1:0]  credit_q, credit_d;
    logic                         valid_out_q, valid_out_d;
    logic [WIDTH_PORT-1:0]        data_out_q, data_out_d;
    logic [WIDTH_SEL-1:0]         nub_out_q, nub_out_d;
    logic                         err_q, err_d;

    logic [WIDTH_SEL-1:0]  req_nub_arr  [PORT_NUB];
    logic [DATA_WIDTH-1:0] req_data_arr [PORT_NUB];
    logic [PORT_NUB-1:0]   eligible;
    logic [PORT_NUB-1:0]   pick_onehot;
    logic [WIDTH_SEL-1:0]  pick_idx;
    logic                  pick_any;
    logic [WIDTH_SEL-1:0]  pick_nub;
    logic                  grant_fire;

    genvar gi;
    generate
        for (gi = 0; gi < PORT_NUB; gi++) begin : g_req
            assign req_nub_arr[gi]  = req_nub[gi*WIDTH_SEL +: WIDTH_SEL];
            assign req_data_arr[gi] = req_data[gi*DATA_WIDTH +: DATA_WIDTH];
            assign eligible[gi]     = req_valid[gi] && (credit_q[req_nub_arr[gi]] < CREDIT_MAX);
        end
    endgenerate

    rr_picker #(
        .PORT_NUB  (PORT_NUB),
        .WIDTH_SEL (WIDTH_SEL)
    ) u_rr_picker (
        .eligible     (eligible),
        .rr_ptr       (rr_ptr_q),
        .grant_onehot (pick_onehot),
        .grant_idx    (pick_idx),
        .grant_any    (pick_any)
    );

    always_comb begin
        pick_nub = '0;
        for (int i = 0; i < PORT_NUB; i++) begin
            if (pick_onehot[i]) begin
                pick_nub = pick_nub | req_nub_arr[i];
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        gnt_d       = gnt_q;
        dest_d      = dest_q;
        valid_out_d = 1'b0;
        data_out_d  = data_out_q;
        nub_out_d   = nub_out_q;
        req_ready   = '0;
        grant_fire  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (pick_any) begin
                    gnt_d      = pick_idx;
                    dest_d     = pick_nub;
                    grant_fire = 1'b1;
                    state_d    = ST_XFER;
                end
            end
            ST_XFER: begin
                req_ready[gnt_q] = !voq_full_in;
                if (req_valid[gnt_q] && !voq_full_in) begin
                    valid_out_d = 1'b1;
                    data_out_d  = {gnt_q, req_data_arr[gnt_q]};
                    nub_out_d   = dest_q;
                    if (req_last[gnt_q]) begin
                        state_d  = ST_IDLE;
                        rr_ptr_d = (gnt_q == LAST_IDX) ? '0 : gnt_q + WIDTH_SEL'(1);
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // A grant and a done for the same destination cancel; a done with nothing
    // outstanding is a protocol error from the chain and is latched.
    always_comb begin
        credit_d = credit_q;
        err_d    = err_q;
        for (int d = 0; d < PORT_NUB; d++) begin
            if (grant_fire && (pick_nub == WIDTH_SEL'(d))) begin
                if (!done_in[d]) begin
                    credit_d[d] = credit_q[d] + CW'(1);
                end
            end else if (done_in[d]) begin
                if (credit_q[d] == '0) begin
                    err_d = 1'b1;
                end else begin
                    credit_d[d] = credit_q[d] - CW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            rr_ptr_q    <= '0;
            gnt_q       <= '0;
            dest_q      <= '0;
            credit_q    <= '0;
            valid_out_q <= 1'b0;
            data_out_q  <= '0;
            nub_out_q   <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            gnt_q       <= gnt_d;
            dest_q      <= dest_d;
            credit_q    <= credit_d;
            valid_out_q <= valid_out_d;
            data_out_q  <= data_out_d;
            nub_out_q   <= nub_out_d;
            err_q       <= err_d;
        end
    end

    assign valid_out = valid_out_q;
    assign data_out  = data_out_q;
    assign nub_out   = nub_out_q;
    assign err_out   = err_q;

endmodule

// File: tb/tb_voq_in_arbiter.sv
// Self-checking bench: frame-level requester queues, a behavioural arbiter model
// compared every cycle, directed scenarios with literal expectations, then random traffic.
module tb_voq_in_arbiter;

    localparam int N  = 4;
    localparam int DW = 8;
    localparam int OM = 2;
    localparam int WS = 2;
    localparam int TR = 64;

    logic            clk = 1'b0;
    logic            rst_n = 1'b1;
    logic [N-1:0]    req_valid = '0;
    logic [N-1:0]    req_last = '0;
    logic [N*DW-1:0] req_data = '0;
    logic [N*WS-1:0] req_nub = '0;
    logic [N-1:0]    req_ready;
    logic            voq_full_in = 1'b0;
    logic [N-1:0]    done_in = '0;
    logic            valid_out;
    logic [WS+DW-1:0] data_out;
    logic [WS-1:0]   nub_out;
    logic            err_out;

    voq_in_arbiter #(
        .PORT_NUB        (N),
        .DATA_WIDTH      (DW),
        .OUTSTANDING_MAX (OM)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_valid   (req_valid),
        .req_last    (req_last),
        .req_data    (req_data),
        .req_nub     (req_nub),
        .req_ready   (req_ready),
        .voq_full_in (voq_full_in),
        .done_in     (done_in),
        .valid_out   (valid_out),
        .data_out    (data_out),
        .nub_out     (nub_out),
        .err_out     (err_out)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;

    // behavioural model of the arbiter
    int m_busy, m_owner, m_dest, m_rr;
    int m_cred [N];
    int m_valid, m_src, m_pay, m_nub, m_err;

    // requester frame queues
    int fq_dest [N][$];
    int fq_len  [N][$];
    int fq_seed [N][$];
    int beat    [N];

    int gap_pct, full_from, full_to, rand_mode;
    int done_at [N];

    int tr_v [TR];
    int tr_src [TR];
    int tr_pay [TR];
    int tr_nub [TR];
    int tr_err [TR];

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push(input int i, input int dest, input int len, input int seed);
        fq_dest[i].push_back(dest);
        fq_len[i].push_back(len);
        fq_seed[i].push_back(seed);
    endtask

    task automatic drive_inputs();
        for (int i = 0; i < N; i++) begin
            if (fq_len[i].size() > 0) begin
                req_valid[i]          = ($urandom_range(99) >= gap_pct);
                req_nub[i*WS +: WS]   = WS'(fq_dest[i][0]);
                req_data[i*DW +: DW]  = DW'(fq_seed[i][0] + beat[i]);
                req_last[i]           = (beat[i] == fq_len[i][0] - 1);
            end else begin
                req_valid[i]          = 1'b0;
                req_last[i]           = 1'($urandom_range(1));
                req_nub[i*WS +: WS]   = WS'($urandom_range(3));
                req_data[i*DW +: DW]  = DW'($urandom);
            end
        end
        if (rand_mode != 0) begin
            voq_full_in = ($urandom_range(99) < 20);
        end else begin
            voq_full_in = (cyc >= full_from) && (cyc <= full_to);
        end
        for (int d = 0; d < N; d++) begin
            if (rand_mode != 0) begin
                done_in[d] = (m_cred[d] > 0) ? ($urandom_range(99) < 12) : ($urandom_range(999) < 3);
            end else begin
                done_in[d] = (done_at[d] == cyc);
            end
        end
    endtask

    // One clock cycle: drive, check combinational ready, advance the model,
    // clock, then check registered outputs against the model.
    task automatic step();
        int exp_ready, grant, gdest, acc, owner, last, idx, inc;
        drive_inputs();
        #1;
        exp_ready = (m_busy != 0 && !voq_full_in) ? (1 << m_owner) : 0;
        chk("req_ready", int'(req_ready), exp_ready);

        grant = -1;
        gdest = -1;
        acc   = 0;
        last  = 0;
        owner = m_owner;
        if (m_busy == 0) begin
            for (int k = 0; k < N; k++) begin
                idx = (m_rr + k) % N;
                if (grant < 0 && req_valid[idx] && m_cred[int'(req_nub[idx*WS +: WS])] < OM) begin
                    grant = idx;
                end
            end
            if (grant >= 0) begin
                gdest   = int'(req_nub[grant*WS +: WS]);
                m_busy  = 1;
                m_owner = grant;
                m_dest  = gdest;
            end
        end else if (req_valid[owner] && !voq_full_in) begin
            acc   = 1;
            last  = int'(req_last[owner]);
            m_src = owner;
            m_pay = int'(req_data[owner*DW +: DW]);
            m_nub = m_dest;
            if (last != 0) begin
                m_busy = 0;
                m_rr   = (owner + 1) % N;
            end
        end
        m_valid = acc;
        for (int d = 0; d < N; d++) begin
            inc = (gdest == d) ? 1 : 0;
            if (inc != 0 && !done_in[d]) begin
                m_cred[d]++;
            end else if (inc == 0 && done_in[d]) begin
                if (m_cred[d] == 0) m_err = 1;
                else m_cred[d]--;
            end
        end

        @(posedge clk);
        @(negedge clk);
        chk("valid_out", int'(valid_out), m_valid);
        chk("err_out", int'(err_out), m_err);
        if (m_valid != 0) begin
            chk("data_src", int'(data_out[WS+DW-1:DW]), m_src);
            chk("data_payload", int'(data_out[DW-1:0]), m_pay);
            chk("nub_out", int'(nub_out), m_nub);
            $display("cycle %0d beat src=%0d dest=%0d payload=%02h", cyc + 1,
                     int'(data_out[WS+DW-1:DW]), int'(nub_out), int'(data_out[DW-1:0]));
        end
        if (cyc + 1 < TR) begin
            tr_v[cyc+1]   = int'(valid_out);
            tr_src[cyc+1] = int'(data_out[WS+DW-1:DW]);
            tr_pay[cyc+1] = int'(data_out[DW-1:0]);
            tr_nub[cyc+1] = int'(nub_out);
            tr_err[cyc+1] = int'(err_out);
        end
        if (acc != 0) begin
            beat[owner]++;
            if (last != 0) begin
                void'(fq_dest[owner].pop_front());
                void'(fq_len[owner].pop_front());
                void'(fq_seed[owner].pop_front());
                beat[owner] = 0;
            end
        end
        cyc++;
    endtask

    task automatic run(input int n);
        repeat (n) step();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req_valid = '0;
        done_in = '0;
        voq_full_in = 1'b0;
        #1;
        chk("rst_valid_out", int'(valid_out), 0);
        chk("rst_data_out", int'(data_out), 0);
        chk("rst_nub_out", int'(nub_out), 0);
        chk("rst_err_out", int'(err_out), 0);
        chk("rst_req_ready", int'(req_ready), 0);
        m_busy = 0; m_owner = 0; m_dest = 0; m_rr = 0;
        m_valid = 0; m_src = 0; m_pay = 0; m_nub = 0; m_err = 0;
        for (int i = 0; i < N; i++) begin
            m_cred[i] = 0;
            beat[i] = 0;
            done_at[i] = -1;
            fq_dest[i].delete();
            fq_len[i].delete();
            fq_seed[i].delete();
        end
        for (int t = 0; t < TR; t++) begin
            tr_v[t] = 0; tr_src[t] = 0; tr_pay[t] = 0; tr_nub[t] = 0; tr_err[t] = 0;
        end
        gap_pct = 0; full_from = 1; full_to = 0; rand_mode = 0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        cyc = 0;
    endtask

    initial begin
        int lows;
        #2;

        // single 3-beat frame from requester 2 to destination 1
        do_reset();
        push(2, 1, 3, 'h10);
        run(7);
        chk("s1_v1", tr_v[1], 0);
        chk("s1_v2", tr_v[2], 1);
        chk("s1_v4", tr_v[4], 1);
        chk("s1_v5", tr_v[5], 0);
        chk("s1_src", tr_src[2], 2);
        chk("s1_nub", tr_nub[3], 1);
        chk("s1_pay", tr_pay[4], 'h12);
        chk("s1_model_cred1", m_cred[1], 1);
        chk("s1_model_rr", m_rr, 3);
        push(0, 0, 1, 'h20);
        push(3, 0, 1, 'h30);
        run(6);
        chk("s1_rr_first", tr_src[9], 3);
        chk("s1_rr_second", tr_src[11], 0);

        // fairness with 1-beat frames from every requester
        do_reset();
        for (int i = 0; i < N; i++) begin
            push(i, i, 1, 'h50 + i * 16);
            push(i, i, 1, 'h58 + i * 16);
        end
        run(12);
        chk("s2_order0", tr_src[2], 0);
        chk("s2_order1", tr_src[4], 1);
        chk("s2_order2", tr_src[6], 2);
        chk("s2_order3", tr_src[8], 3);
        chk("s2_order4", tr_src[10], 0);
        chk("s2_bubble", tr_v[3] + tr_v[5], 0);

        // backpressure for three cycles mid-frame
        do_reset();
        push(0, 2, 6, 'h40);
        full_from = 3;
        full_to = 5;
        run(12);
        lows = 0;
        for (int t = 2; t <= 10; t++) lows += (tr_v[t] == 0) ? 1 : 0;
        chk("s3_low_cycles", lows, 3);
        chk("s3_beats", tr_v[2] + tr_v[3] + tr_v[7] + tr_v[8] + tr_v[9] + tr_v[10], 6);
        chk("s3_pay_resume", tr_pay[7], 'h42);
        chk("s3_pay_last", tr_pay[10], 'h45);

        // credit limit on destination 3, released by done_in[3]
        do_reset();
        push(0, 3, 1, 'hA0);
        push(1, 3, 1, 'hB0);
        push(2, 3, 1, 'hC0);
        push(3, 0, 1, 'hD0);
        done_at[3] = 7;
        run(14);
        chk("s4_bypass_src", tr_src[6], 3);
        chk("s4_blocked8", tr_v[8], 0);
        chk("s4_blocked9", tr_v[9], 0);
        chk("s4_unblock_v", tr_v[10], 1);
        chk("s4_unblock_src", tr_src[10], 2);

        // grant and done for the same destination together; done at zero credit
        do_reset();
        for (int f = 0; f < 4; f++) push(1, 1, 1, 'h30 + f);
        done_at[1] = 2;
        done_at[2] = 10;
        run(16);
        chk("s5_third_v", tr_v[6], 1);
        chk("s5_fourth_blocked", tr_v[8], 0);
        chk("s5_model_cred1", m_cred[1], 2);
        chk("s5_err_before", tr_err[10], 0);
        chk("s5_err_set", tr_err[11], 1);
        chk("s5_err_sticky", tr_err[16], 1);

        // reset in the middle of a 4-beat frame
        do_reset();
        push(1, 1, 1, 'h60);
        run(2);
        push(0, 1, 4, 'h70);
        run(3);
        chk("s6_pre_pay", tr_pay[5], 'h71);
        do_reset();
        push(0, 1, 1, 'h80);
        push(2, 1, 1, 'h90);
        run(6);
        chk("s6_first_v", tr_v[2], 1);
        chk("s6_first_src", tr_src[2], 0);
        chk("s6_first_pay", tr_pay[2], 'h80);
        chk("s6_second_src", tr_src[4], 2);

        // random traffic against the model
        do_reset();
        rand_mode = 1;
        gap_pct = 20;
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < N; i++) begin
                if (fq_len[i].size() == 0 && $urandom_range(3) == 0) begin
                    push(i, int'($urandom_range(N - 1)), int'($urandom_range(4, 1)), int'($urandom_range(255)));
                end
            end
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
